rob_param_commit: RTL and testbench
===================================

// Module: rob_param_commit
// PURPOSE
//  Parametrised reorder buffer: the in-order retirement point between dispatcher, N CDB write-back channels, LSB, regfile, predictor and fetch.
//  Adds over the previous ROB: configurable depth and CDB count, wrap-bit pointers, same-cycle CDB operand bypass,
//  JALR target-mismatch recovery, one-shot load release, and branch performance counters.
// PARAMETERS
//  DEPTH      16  entries, power of 2, >=4
//  NUM_CDB    2   write-back channels (RS, LSB, ...)
//  ID_W       4   log2(DEPTH); rob tag width
//  DATA_W     32  value/address width
//  REG_W      5   arch register index width
//  OPC_W      6   opcode-class width
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  rdy            in   1             global enable; 0 = freeze
//  disp_valid     in   1             dispatch request
//  disp_ready     out  1             !full; entry allocated iff disp_valid&&disp_ready
//  disp_id        out  ID_W          tag of allocated entry (= tail index)
//  disp_opc       in   OPC_W         opcode class
//  disp_rd        in   REG_W         destination register
//  disp_pc        in   DATA_W        instruction PC
//  disp_pred_pc   in   DATA_W        predicted next PC
//  disp_pred_tk   in   1             predicted taken
//  qj_valid/qk_valid in 1 each       operand has a tag to look up
//  qj_id/qk_id    in   ID_W          operand tags
//  qj_rdy/qk_rdy  out  1 each        value available (entry ready, or CDB hit this cycle, or !q*_valid)
//  vj/vk          out  DATA_W each   value (0 when !q*_valid)
//  cdb_valid      in   NUM_CDB       per-channel write-back valid
//  cdb_id         in   NUM_CDB*ID_W  tags, channel c at [c*ID_W +: ID_W]
//  cdb_value      in   NUM_CDB*DATA_W results
//  cdb_taken      in   NUM_CDB       actual branch outcome
//  cdb_npc        in   NUM_CDB*DATA_W actual next PC
//  rf_we/rf_rd/rf_val/rf_id out 1/REG_W/DATA_W/ID_W  retire write; rf_id clears matching rename tag
//  lsb_go         out  1             pulse: release head load or commit head store
//  lsb_id         out  ID_W          tag for lsb_go
//  bp_upd/bp_pc/bp_taken out 1/DATA_W/1  predictor training on branch/jump retire
//  flush          out  1             one-cycle pulse: mispredict, squash pipeline
//  flush_pc       out  DATA_W        fetch redirect target, valid with flush
//  count          out  ID_W+1        occupied entries
//  br_total/br_miss out 32 each      retired branch and mispredict counters
// BEHAVIOUR
//  - Reset (and flush cycle+1): head=tail=0, all busy/ready/released=0, every output 0; counters cleared by rst only.
//  - rdy=0: no state changes; pulse outputs (rf_we, lsb_go, bp_upd, flush) forced 0.
//  - Pointers ID_W+1 bits with wrap bit; count=tail-head; full=(count==DEPTH); empty=(count==0).
//  - Dispatch: allocate at tail, busy=1, ready=0; tail+1. Dispatch and retire in one cycle legal; count unchanged.
//  - CDB: channel c writes only if entry busy; sets ready, value, taken, npc. Same tag on several channels: lowest c wins.
//  - Operand lookup combinational: entry ready -> stored value; else CDB hit this cycle -> bypass value; else rdy=0.
//  - Retire (one per cycle, head busy):
//    load, !ready, !released -> lsb_go=1, lsb_id=head, released=1, no retire; wait for CDB.
//    store -> retire at head without ready; lsb_go=1, lsb_id=head.
//    other/ready load -> retire; rf_we=1 iff class writes rd and rd!=0.
//  - Branch/JAL/JALR retire: bp_upd=1; br_total++.
//    Mispredict = (pred_tk!=taken) || (taken && pred_pc!=npc); then flush=1, flush_pc=npc, br_miss++.
//  - Mispredict retire registers outputs; next cycle is the flush cycle: clears all entries, ignores dispatch and CDB.
//  - Retire outputs registered: one-cycle latency from ready-at-head to rf_we/lsb_go.
//  - Empty: no retire outputs. Full: disp_ready=0 even if a retire occurs this cycle.
// STRUCTURE
//  - Shared package cpu_defs: opcode-class encodings, is_load/is_store/is_branch/writes_rd functions, widths.
//  - Sub-module rob_wb_select: priority merge of NUM_CDB channels into per-entry write enables + data.
// TESTING
//  1 rst, DEPTH=16: dispatch 16 ADDs -> disp_ready=0 at count=16; retire one -> disp_ready=1, tail wraps to 0.
//  2 ADD rd=5 tag 3, CDB ch1 value 0x2A -> rf_we=1, rf_rd=5, rf_val=0x2A, rf_id=3 one cycle after ready at head.
//  3 qj_id=2 while CDB ch0 writes tag 2 value 7 -> qj_rdy=1, vj=7 same cycle.
//  4 load at head -> lsb_go once with lsb_id=head, no repeat while waiting; CDB 0x55 -> rf_val=0x55.
//  5 BEQ pred_tk=0, CDB taken=1 npc=0x100, 4 younger entries -> flush=1, flush_pc=0x100, br_miss=1, count=0 next.
//  6 JALR pred_pc=0x200, npc=0x204 -> flush, flush_pc=0x204; ch0 and ch1 same tag -> ch0 value kept.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode classes and
// classification helpers used by the ROB.
package cpu_defs;

  localparam int CPU_OPC_W  = 6;
  localparam int CPU_REG_W  = 5;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [CPU_OPC_W-1:0] {
    OPC_NOP    = 6'd0,
    OPC_ALU    = 6'd1,
    OPC_LUI    = 6'd2,
    OPC_LOAD   = 6'd3,
    OPC_STORE  = 6'd4,
    OPC_BRANCH = 6'd5,
    OPC_JAL    = 6'd6,
    OPC_JALR   = 6'd7
  } opc_e;

  function automatic logic is_load(
    input logic [CPU_OPC_W-1:0] o
  );
    return o == OPC_LOAD;
  endfunction

  function automatic logic is_store(
    input logic [CPU_OPC_W-1:0] o
  );
    return o == OPC_STORE;
  endfunction

  function automatic logic is_branch(
    input logic [CPU_OPC_W-1:0] o
  );
    return (o == OPC_BRANCH) ||
           (o == OPC_JAL) ||
           (o == OPC_JALR);
  endfunction

  function automatic logic writes_rd(
    input logic [CPU_OPC_W-1:0] o
  );
    return (o == OPC_ALU) ||
           (o == OPC_LUI) ||
           (o == OPC_LOAD) ||
           (o == OPC_JAL) ||
           (o == OPC_JALR);
  endfunction

endpackage

// File: rtl/rob_wb_select.sv
// Priority merge of CDB channels into per-entry
// write enables; lowest channel wins on tag clash.
module rob_wb_select #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32
) (
  input  logic [DEPTH-1:0]               busy,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0]        cdb_id,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_value,
  input  logic [NUM_CDB-1:0]             cdb_taken,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_npc,
  output logic [DEPTH-1:0]               wb_we,
  output logic [DEPTH-1:0][DATA_W-1:0]   wb_value,
  output logic [DEPTH-1:0]               wb_taken,
  output logic [DEPTH-1:0][DATA_W-1:0]   wb_npc
);

  logic [ID_W-1:0] idx;

  // Walk channels high to low so channel 0 overrides last
  always_comb begin
    wb_we    = '0;
    wb_value = '0;
    wb_taken = '0;
    wb_npc   = '0;
    idx      = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      idx = cdb_id[c*ID_W +: ID_W];
      if (cdb_valid[c] && busy[idx]) begin
        wb_we[idx]    = 1'b1;
        wb_value[idx] = cdb_value[c*DATA_W +: DATA_W];
        wb_taken[idx] = cdb_taken[c];
        wb_npc[idx]   = cdb_npc[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rob_param_commit.sv
// Parametrised reorder buffer: in-order retire,
// CDB bypass, load release and mispredict flush.
module rob_param_commit
  import cpu_defs::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int OPC_W   = CPU_OPC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  output logic [ID_W-1:0]           disp_id,
  input  logic [OPC_W-1:0]          disp_opc,
  input  logic [REG_W-1:0]          disp_rd,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_pred_pc,
  input  logic                      disp_pred_tk,
  input  logic                      qj_valid,
  input  logic                      qk_valid,
  input  logic [ID_W-1:0]           qj_id,
  input  logic [ID_W-1:0]           qk_id,
  output logic                      qj_rdy,
  output logic                      qk_rdy,
  output logic [DATA_W-1:0]         vj,
  output logic [DATA_W-1:0]         vk,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0]   cdb_id,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  input  logic [NUM_CDB-1:0]        cdb_taken,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_npc,
  output logic                      rf_we,
  output logic [REG_W-1:0]          rf_rd,
  output logic [DATA_W-1:0]         rf_val,
  output logic [ID_W-1:0]           rf_id,
  output logic                      lsb_go,
  output logic [ID_W-1:0]           lsb_id,
  output logic                      bp_upd,
  output logic [DATA_W-1:0]         bp_pc,
  output logic                      bp_taken,
  output logic                      flush,
  output logic [DATA_W-1:0]         flush_pc,
  output logic [ID_W:0]             count,
  output logic [31:0]               br_total,
  output logic [31:0]               br_miss
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

  logic [ID_W:0]       head, tail, cnt;
  logic [DEPTH-1:0]    busy, rdyb, rel, ptk, tkn;
  logic [OPC_W-1:0]    opc  [DEPTH];
  logic [REG_W-1:0]    rd   [DEPTH];
  logic [DATA_W-1:0]   pc   [DEPTH];
  logic [DATA_W-1:0]   ppc  [DEPTH];
  logic [DATA_W-1:0]   val  [DEPTH];
  logic [DATA_W-1:0]   npc  [DEPTH];

  logic [DEPTH-1:0]             wb_we, wb_taken;
  logic [DEPTH-1:0][DATA_W-1:0] wb_value, wb_npc;

  logic rf_we_q, lsb_go_q, bp_upd_q, flush_q;
  logic full, do_disp, do_rel, do_ret, mis;
  logic [ID_W-1:0]  hd, tl;
  logic [OPC_W-1:0] h_opc;

  rob_wb_select #(
    .DEPTH   (DEPTH),
    .NUM_CDB (NUM_CDB),
    .ID_W    (ID_W),
    .DATA_W  (DATA_W)
  ) u_wb (
    .busy      (busy),
    .cdb_valid (cdb_valid),
    .cdb_id    (cdb_id),
    .cdb_value (cdb_value),
    .cdb_taken (cdb_taken),
    .cdb_npc   (cdb_npc),
    .wb_we     (wb_we),
    .wb_value  (wb_value),
    .wb_taken  (wb_taken),
    .wb_npc    (wb_npc)
  );

  // Occupancy, dispatch gating and head retire decision
  always_comb begin
    cnt     = tail - head;
    full    = (cnt == FULL_CNT);
    hd      = head[ID_W-1:0];
    tl      = tail[ID_W-1:0];
    h_opc   = opc[hd];
    do_disp = disp_valid && disp_ready;
    do_rel  = 1'b0;
    do_ret  = 1'b0;
    mis     = 1'b0;
    if (rdy && !flush_q && busy[hd]) begin
      do_rel = is_load(h_opc) && !rdyb[hd] && !rel[hd];
      do_ret = is_store(h_opc) || rdyb[hd];
      mis    = do_ret && is_branch(h_opc) &&
               ((ptk[hd] != tkn[hd]) ||
                (tkn[hd] && (ppc[hd] != npc[hd])));
    end
  end

  assign disp_ready = rdy && !full && !flush_q;
  assign disp_id    = tl;
  assign count      = cnt;
  assign rf_we      = rf_we_q && rdy;
  assign lsb_go     = lsb_go_q && rdy;
  assign bp_upd     = bp_upd_q && rdy;
  assign flush      = flush_q && rdy;

  // Operand lookup: stored value first, then CDB bypass
  always_comb begin
    qj_rdy = 1'b1;
    vj     = '0;
    if (qj_valid) begin
      if (rdyb[qj_id])       vj = val[qj_id];
      else if (wb_we[qj_id]) vj = wb_value[qj_id];
      else                   qj_rdy = 1'b0;
    end
  end

  // Same lookup for the second operand
  always_comb begin
    qk_rdy = 1'b1;
    vk     = '0;
    if (qk_valid) begin
      if (rdyb[qk_id])       vk = val[qk_id];
      else if (wb_we[qk_id]) vk = wb_value[qk_id];
      else                   qk_rdy = 1'b0;
    end
  end

  // Control state, registered retire outputs, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      busy     <= '0;
      rdyb     <= '0;
      rel      <= '0;
      rf_we_q  <= 1'b0;
      lsb_go_q <= 1'b0;
      bp_upd_q <= 1'b0;
      flush_q  <= 1'b0;
      rf_rd    <= '0;
      rf_val   <= '0;
      rf_id    <= '0;
      lsb_id   <= '0;
      bp_pc    <= '0;
      bp_taken <= 1'b0;
      flush_pc <= '0;
      br_total <= '0;
      br_miss  <= '0;
    end else if (rdy) begin
      rf_we_q  <= 1'b0;
      lsb_go_q <= 1'b0;
      bp_upd_q <= 1'b0;
      flush_q  <= 1'b0;
      rf_rd    <= '0;
      rf_val   <= '0;
      rf_id    <= '0;
      lsb_id   <= '0;
      bp_pc    <= '0;
      bp_taken <= 1'b0;
      flush_pc <= '0;
      if (flush_q) begin
        head <= '0;
        tail <= '0;
        busy <= '0;
        rdyb <= '0;
        rel  <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_we[i]) rdyb[i] <= 1'b1;
        end
        if (do_disp) begin
          busy[tl] <= 1'b1;
          rdyb[tl] <= 1'b0;
          rel[tl]  <= 1'b0;
          tail     <= tail + 1'b1;
        end
        if (do_rel) begin
          rel[hd]  <= 1'b1;
          lsb_go_q <= 1'b1;
          lsb_id   <= hd;
        end
        if (do_ret) begin
          busy[hd] <= 1'b0;
          rdyb[hd] <= 1'b0;
          rel[hd]  <= 1'b0;
          head     <= head + 1'b1;
          if (writes_rd(h_opc) && (rd[hd] != '0)) begin
            rf_we_q <= 1'b1;
            rf_rd   <= rd[hd];
            rf_val  <= val[hd];
            rf_id   <= hd;
          end
          if (is_store(h_opc)) begin
            lsb_go_q <= 1'b1;
            lsb_id   <= hd;
          end
          if (is_branch(h_opc)) begin
            bp_upd_q <= 1'b1;
            bp_pc    <= pc[hd];
            bp_taken <= tkn[hd];
            br_total <= br_total + 32'd1;
          end
          if (mis) begin
            flush_q  <= 1'b1;
            flush_pc <= npc[hd];
            br_miss  <= br_miss + 32'd1;
          end
        end
      end
    end
  end

  // Entry payload: dispatch fields and CDB results
  always_ff @(posedge clk) begin
    if (rdy && !flush_q && !rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_we[i]) begin
          val[i] <= wb_value[i];
          tkn[i] <= wb_taken[i];
          npc[i] <= wb_npc[i];
        end
      end
      if (do_disp) begin
        opc[tl] <= disp_opc;
        rd[tl]  <= disp_rd;
        pc[tl]  <= disp_pc;
        ppc[tl] <= disp_pred_pc;
        ptk[tl] <= disp_pred_tk;
      end
    end
  end

endmodule

// File: tb/tb_rob_param_commit.sv
// Directed bench for rob_param_commit with
// hand-computed expectations.
module tb_rob_param_commit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_id;
  logic [5:0]  disp_opc;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc, disp_pred_pc;
  logic        disp_pred_tk;
  logic        qj_valid, qk_valid;
  logic [3:0]  qj_id, qk_id;
  logic        qj_rdy, qk_rdy;
  logic [31:0] vj, vk;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_id;
  logic [63:0] cdb_value;
  logic [1:0]  cdb_taken;
  logic [63:0] cdb_npc;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_val;
  logic [3:0]  rf_id;
  logic        lsb_go;
  logic [3:0]  lsb_id;
  logic        bp_upd;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  count;
  logic [31:0] br_total, br_miss;

  int checks = 0;
  int errors = 0;

  rob_param_commit dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_id      (disp_id),
    .disp_opc     (disp_opc),
    .disp_rd      (disp_rd),
    .disp_pc      (disp_pc),
    .disp_pred_pc (disp_pred_pc),
    .disp_pred_tk (disp_pred_tk),
    .qj_valid     (qj_valid),
    .qk_valid     (qk_valid),
    .qj_id        (qj_id),
    .qk_id        (qk_id),
    .qj_rdy       (qj_rdy),
    .qk_rdy       (qk_rdy),
    .vj           (vj),
    .vk           (vk),
    .cdb_valid    (cdb_valid),
    .cdb_id       (cdb_id),
    .cdb_value    (cdb_value),
    .cdb_taken    (cdb_taken),
    .cdb_npc      (cdb_npc),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_val       (rf_val),
    .rf_id        (rf_id),
    .lsb_go       (lsb_go),
    .lsb_id       (lsb_id),
    .bp_upd       (bp_upd),
    .bp_pc        (bp_pc),
    .bp_taken     (bp_taken),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .count        (count),
    .br_total     (br_total),
    .br_miss      (br_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0;
    cdb_id    = '0;
    cdb_value = '0;
    cdb_taken = '0;
    cdb_npc   = '0;
  endtask

  task automatic set_cdb(input int c,
                         input logic [3:0] id,
                         input logic [31:0] v,
                         input logic t,
                         input logic [31:0] n);
    cdb_valid[c]          = 1'b1;
    cdb_id[c*4 +: 4]      = id;
    cdb_value[c*32 +: 32] = v;
    cdb_taken[c]          = t;
    cdb_npc[c*32 +: 32]   = n;
  endtask

  task automatic set_disp(input logic [5:0] o,
                          input logic [4:0] r,
                          input logic [31:0] p,
                          input logic [31:0] pp,
                          input logic tk);
    disp_opc     = o;
    disp_rd      = r;
    disp_pc      = p;
    disp_pred_pc = pp;
    disp_pred_tk = tk;
  endtask

  task automatic disp(input logic [5:0] o,
                      input logic [4:0] r,
                      input logic [31:0] p,
                      input logic [31:0] pp,
                      input logic tk);
    set_disp(o, r, p, pp, tk);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    rdy        = 1'b1;
    disp_valid = 1'b0;
    qj_valid   = 1'b0;
    qk_valid   = 1'b0;
    qj_id      = '0;
    qk_id      = '0;
    set_disp(OPC_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
    clr_cdb();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [3:0] last_id;

    // reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_id", disp_id, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_br_total", br_total, 0);

    // fill to 16, then retire one and wrap tail
    for (int i = 0; i < 16; i++) begin
      chk("fill_id", disp_id, i);
      disp(OPC_ALU, 5'd1, 32'h10 + i*4, 32'h14 + i*4, 1'b0);
    end
    chk("full_count", count, 16);
    chk("full_ready", disp_ready, 0);
    disp(OPC_ALU, 5'd1, 32'h0, 32'h4, 1'b0);
    chk("full_no_alloc", count, 16);
    set_cdb(0, 4'd0, 32'h11, 1'b0, 32'h0);
    tick();
    clr_cdb();
    chk("full_retire_ready", disp_ready, 0);
    chk("full_retire_count", count, 16);
    tick();
    chk("wrap_rf_we", rf_we, 1);
    chk("wrap_rf_val", rf_val, 32'h11);
    chk("wrap_count", count, 15);
    chk("wrap_ready", disp_ready, 1);
    chk("wrap_id", disp_id, 0);

    // ADD rd=5 at tag 3, completed on channel 1
    do_reset();
    disp(OPC_ALU, 5'd0, 32'h0, 32'h4, 1'b0);
    disp(OPC_ALU, 5'd0, 32'h4, 32'h8, 1'b0);
    disp(OPC_ALU, 5'd0, 32'h8, 32'hc, 1'b0);
    disp(OPC_ALU, 5'd5, 32'hc, 32'h10, 1'b0);
    set_cdb(0, 4'd0, 32'h1, 1'b0, 32'h0);
    set_cdb(1, 4'd1, 32'h2, 1'b0, 32'h0);
    tick();
    clr_cdb();
    set_cdb(0, 4'd2, 32'h3, 1'b0, 32'h0);
    tick();
    clr_cdb();
    tick();
    tick();
    tick();
    chk("add_count_pre", count, 1);
    chk("add_rd0_no_we", rf_we, 0);
    set_cdb(1, 4'd3, 32'h2A, 1'b0, 32'h0);
    tick();
    clr_cdb();
    chk("add_latency", rf_we, 0);
    tick();
    chk("add_rf_we", rf_we, 1);
    chk("add_rf_rd", rf_rd, 5);
    chk("add_rf_val", rf_val, 32'h2A);
    chk("add_rf_id", rf_id, 3);
    chk("add_count", count, 0);
    tick();
    chk("add_pulse", rf_we, 0);

    // same-cycle CDB bypass of an operand
    do_reset();
    disp(OPC_ALU, 5'd1, 32'h0, 32'h4, 1'b0);
    disp(OPC_ALU, 5'd2, 32'h4, 32'h8, 1'b0);
    disp(OPC_ALU, 5'd3, 32'h8, 32'hc, 1'b0);
    qj_valid = 1'b1;
    qj_id    = 4'd2;
    qk_valid = 1'b1;
    qk_id    = 4'd1;
    set_cdb(0, 4'd2, 32'd7, 1'b0, 32'h0);
    #1;
    chk("byp_qj_rdy", qj_rdy, 1);
    chk("byp_vj", vj, 7);
    chk("byp_qk_rdy", qk_rdy, 0);
    tick();
    clr_cdb();
    #1;
    chk("stored_qj_rdy", qj_rdy, 1);
    chk("stored_vj", vj, 7);
    qj_valid = 1'b0;
    qk_valid = 1'b0;
    #1;
    chk("novalid_rdy", qj_rdy, 1);
    chk("novalid_vj", vj, 0);

    // load release once, then store commit
    do_reset();
    disp(OPC_LOAD, 5'd7, 32'h20, 32'h24, 1'b0);
    pulses  = 0;
    last_id = 4'hf;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lsb_go) begin
        pulses++;
        last_id = lsb_id;
      end
    end
    chk("ld_go_once", pulses, 1);
    chk("ld_go_id", last_id, 0);
    chk("ld_waiting", count, 1);
    set_cdb(0, 4'd0, 32'h55, 1'b0, 32'h0);
    tick();
    clr_cdb();
    tick();
    chk("ld_rf_we", rf_we, 1);
    chk("ld_rf_rd", rf_rd, 7);
    chk("ld_rf_val", rf_val, 32'h55);
    chk("ld_no_go", lsb_go, 0);
    disp(OPC_STORE, 5'd0, 32'h24, 32'h28, 1'b0);
    tick();
    chk("st_go", lsb_go, 1);
    chk("st_id", lsb_id, 1);
    chk("st_no_we", rf_we, 0);
    chk("st_count", count, 0);

    // freeze: no allocation while rdy=0
    rdy = 1'b0;
    set_disp(OPC_ALU, 5'd1, 32'h0, 32'h4, 1'b0);
    disp_valid = 1'b1;
    #1;
    chk("frz_ready", disp_ready, 0);
    tick();
    disp_valid = 1'b0;
    chk("frz_count", count, 0);
    rdy = 1'b1;

    // BEQ mispredict with four younger entries
    do_reset();
    disp(OPC_BRANCH, 5'd0, 32'h40, 32'h44, 1'b0);
    for (int i = 0; i < 4; i++)
      disp(OPC_ALU, 5'd1, 32'h44 + i*4, 32'h48 + i*4, 1'b0);
    chk("beq_count_pre", count, 5);
    set_cdb(0, 4'd0, 32'h0, 1'b1, 32'h100);
    tick();
    clr_cdb();
    tick();
    chk("beq_flush", flush, 1);
    chk("beq_flush_pc", flush_pc, 32'h100);
    chk("beq_br_miss", br_miss, 1);
    chk("beq_br_total", br_total, 1);
    chk("beq_bp_upd", bp_upd, 1);
    chk("beq_bp_pc", bp_pc, 32'h40);
    chk("beq_bp_taken", bp_taken, 1);
    chk("beq_flush_ready", disp_ready, 0);
    set_disp(OPC_ALU, 5'd1, 32'h0, 32'h4, 1'b0);
    disp_valid = 1'b1;
    set_cdb(0, 4'd1, 32'h9, 1'b0, 32'h0);
    tick();
    disp_valid = 1'b0;
    clr_cdb();
    chk("beq_count_post", count, 0);
    chk("beq_flush_off", flush, 0);
    chk("beq_id_post", disp_id, 0);

    // JALR target mismatch, ch0/ch1 clash on one tag
    disp(OPC_JALR, 5'd1, 32'h80, 32'h200, 1'b1);
    disp(OPC_ALU, 5'd2, 32'h200, 32'h204, 1'b0);
    set_cdb(0, 4'd0, 32'h84, 1'b1, 32'h204);
    set_cdb(1, 4'd0, 32'h99, 1'b1, 32'h300);
    qj_valid = 1'b1;
    qj_id    = 4'd0;
    #1;
    chk("clash_byp", vj, 32'h84);
    tick();
    clr_cdb();
    #1;
    chk("clash_stored", vj, 32'h84);
    qj_valid = 1'b0;
    tick();
    chk("jalr_flush", flush, 1);
    chk("jalr_flush_pc", flush_pc, 32'h204);
    chk("jalr_rf_val", rf_val, 32'h84);
    chk("jalr_br_total", br_total, 2);
    chk("jalr_br_miss", br_miss, 2);
    tick();
    chk("jalr_count_post", count, 0);

    // correctly predicted not-taken branch
    disp(OPC_BRANCH, 5'd0, 32'h300, 32'h304, 1'b0);
    set_cdb(1, 4'd0, 32'h0, 1'b0, 32'h304);
    tick();
    clr_cdb();
    tick();
    chk("ok_bp_upd", bp_upd, 1);
    chk("ok_bp_taken", bp_taken, 0);
    chk("ok_no_flush", flush, 0);
    chk("ok_br_total", br_total, 3);
    chk("ok_br_miss", br_miss, 2);
    chk("ok_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
